pulse_scheduler: RTL and testbench

PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

---
 rtl/pulse_scheduler_pkg.sv | 19 +
 rtl/pulse_scheduler_rr_arbiter.sv | 36 +++
 rtl/pulse_scheduler.sv | 96 +++++++++
 tb/tb_pulse_scheduler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_scheduler_pkg.sv
// Shared definitions for the pulse scheduler: state encoding, parameter
// defaults and an index-width helper.
package pulse_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam int unsigned N_REQ_DEFAULT  = 4;
    localparam int unsigned W_BITS_DEFAULT = 4;

    // Width needed to hold a requester index (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past last_owner,
// so the previous owner has the lowest priority.
module rr_arbiter
    import pulse_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEFAULT,
    parameter int unsigned IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic [N_REQ-1:0] winner,
    output logic [IW-1:0]    winner_idx,
    output logic             any
);

    int unsigned idx;

    // Walk requesters in rotated order and keep the first one asserted.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any        = 1'b0;
        idx        = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            idx = (int'(last_owner) + off) % N_REQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                winner_idx = IW'(idx);
            end
        end
        if (any) begin
            winner[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shared pulse output scheduler: grants one requester at a time a pulse of
// its requested length, followed by a one-cycle gap carrying its done strobe.
module pulse_scheduler
    import pulse_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ  = N_REQ_DEFAULT,
    parameter int unsigned W_BITS = W_BITS_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W_BITS-1:0]  len,
    output logic                     pulse,
    output logic [N_REQ-1:0]         grant,
    output logic [N_REQ-1:0]         done,
    output logic                     busy
);

    localparam int unsigned IW = idx_width(N_REQ);

    state_t            state;
    logic [W_BITS-1:0] count;
    logic [IW-1:0]     last_owner;

    logic [N_REQ-1:0]  arb_winner;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;
    logic [W_BITS-1:0] sel_len;
    logic [W_BITS-1:0] eff_len_m1;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req        (req),
        .last_owner (last_owner),
        .winner     (arb_winner),
        .winner_idx (arb_idx),
        .any        (arb_any)
    );

    // Winner's length minus one, with a zero length treated as one cycle.
    always_comb begin
        sel_len    = len[int'(arb_idx)*W_BITS +: W_BITS];
        eff_len_m1 = (sel_len == '0) ? '0 : sel_len - 1'b1;
    end

    assign busy = (state != IDLE);

    // FSM with counter, length sampling at grant and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            pulse      <= 1'b0;
            grant      <= '0;
            done       <= '0;
            count      <= '0;
            last_owner <= IW'(N_REQ - 1);
        end else begin
            case (state)
                IDLE, GAP: begin
                    done <= '0;
                    if (arb_any) begin
                        state      <= ACTIVE;
                        pulse      <= 1'b1;
                        grant      <= arb_winner;
                        count      <= eff_len_m1;
                        last_owner <= arb_idx;
                    end else begin
                        state <= IDLE;
                        pulse <= 1'b0;
                        grant <= '0;
                    end
                end
                ACTIVE: begin
                    if (count == '0) begin
                        state <= GAP;
                        pulse <= 1'b0;
                        grant <= '0;
                        done  <= grant;
                    end else begin
                        count <= count - 1'b1;
                        done  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    pulse <= 1'b0;
                    grant <= '0;
                    done  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Self-checking bench for pulse_scheduler: a cycle table for the basic
// sequences plus hand-written runs for drop, reset and fairness cases.
module tb_pulse_scheduler;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] len;
    logic        pulse;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] len;
        logic        p;
        logic [3:0]  g;
        logic [3:0]  d;
        logic        b;
    } vec_t;

    vec_t tbl[$];

    pulse_scheduler #(
        .N_REQ  (4),
        .W_BITS (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .len     (len),
        .pulse   (pulse),
        .grant   (grant),
        .done    (done),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void add(input logic [3:0] r, input logic [15:0] l, input logic p,
                                input logic [3:0] g, input logic [3:0] d, input logic b);
        tbl.push_back('{r, l, p, g, d, b});
    endfunction

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int hi;
        int dn_cnt;
        int pulses;
        int width;
        int cycles;
        logic prev_pulse;
        logic [3:0] prev_done;
        logic [3:0] cur_g;
        logic exp_owner;

        reset_n = 1'b1;
        req     = '0;
        len     = '0;
        #2 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_pulse", pulse, 0);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;

        // first edge after reset: idle arbitration with no requests
        add(4'b0000, 16'h0000, 0, 4'b0000, 4'b0000, 0);
        // contention, all len=2: grants 0,1,2,3,0 with 3-cycle period
        for (int k = 0; k < 5; k++) begin
            logic [3:0] g;
            g = 4'b0001 << (k % 4);
            add(4'b1111, 16'h2222, 1, g, 4'b0000, 1);
            add(4'b1111, 16'h2222, 1, g, 4'b0000, 1);
            add((k == 4) ? 4'b1111 : 4'b1111, 16'h2222, 0, 4'b0000, g, 1);
        end
        add(4'b0000, 16'h2222, 0, 4'b0000, 4'b0000, 0);
        // single request, len0=3
        add(4'b0001, 16'h0003, 1, 4'b0001, 4'b0000, 1);
        add(4'b0001, 16'h0003, 1, 4'b0001, 4'b0000, 1);
        add(4'b0001, 16'h0003, 1, 4'b0001, 4'b0000, 1);
        add(4'b0001, 16'h0003, 0, 4'b0000, 4'b0001, 1);
        add(4'b0000, 16'h0003, 0, 4'b0000, 4'b0000, 0);
        add(4'b0000, 16'h0003, 0, 4'b0000, 4'b0000, 0);
        // zero length on requester 2
        add(4'b0100, 16'h0000, 1, 4'b0100, 4'b0000, 1);
        add(4'b0100, 16'h0000, 0, 4'b0000, 4'b0100, 1);
        add(4'b0000, 16'h0000, 0, 4'b0000, 4'b0000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            req = tbl[i].req;
            len = tbl[i].len;
            cycle();
            chk($sformatf("vec%0d_pulse", i), pulse, tbl[i].p);
            chk($sformatf("vec%0d_grant", i), grant, tbl[i].g);
            chk($sformatf("vec%0d_done", i), done, tbl[i].d);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].b);
        end

        // max length on requester 1, req dropped and len changed mid-pulse
        req = 4'b0010;
        len = 16'h00F0;
        hi = 0;
        dn_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            cycle();
            if (pulse) begin
                hi++;
                chk("drop_grant", grant, 4'b0010);
            end
            if (done != 0) begin
                dn_cnt++;
                chk("drop_done", done, 4'b0010);
            end
            if (hi == 2) begin
                req = 4'b0000;
                len = 16'h0020;
            end
            if (!busy && hi > 0) break;
        end
        chk("drop_width", hi, 15);
        chk("drop_done_cnt", dn_cnt, 1);

        // reset mid-pulse of a 10-cycle pulse on requester 2
        req = 4'b0100;
        len = 16'h0A00;
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (pulse) hi++;
            if (hi == 4) break;
        end
        chk("rstmid_pre_pulse", pulse, 1);
        chk("rstmid_pre_grant", grant, 4'b0100);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_pulse", pulse, 0);
        chk("rstmid_grant", grant, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_done", done, 0);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("rstmid_hold_done", done, 0);
            chk("rstmid_hold_pulse", pulse, 0);
        end
        req = 4'b1010;
        len = 16'h0000;
        reset_n = 1'b1;
        cycle();
        chk("rstrel_grant", grant, 4'b0010);
        chk("rstrel_pulse", pulse, 1);
        cycle();
        chk("rstrel_done", done, 4'b0010);
        req = 4'b1000;
        cycle();
        chk("rstrel_grant3", grant, 4'b1000);
        cycle();
        chk("rstrel_done3", done, 4'b1000);
        req = 4'b0000;
        cycle();
        chk("rstrel_idle", busy, 0);

        // fairness: requesters 0 and 1 held for 20 pulses (len0=3, len1=5)
        req = 4'b0011;
        len = 16'h0053;
        prev_pulse = 1'b0;
        prev_done = '0;
        cur_g = '0;
        width = 0;
        pulses = 0;
        cycles = 0;
        exp_owner = 1'b0;
        while (pulses < 20 && cycles < 400) begin
            cycle();
            cycles++;
            chk("fair_grant_onehot", 32'($onehot0(grant)), 1);
            chk("fair_done_onehot", 32'($onehot0(done)), 1);
            chk("fair_done_vs_pulse", 32'((|done) & pulse), 0);
            if (prev_done != 0) chk("fair_gap", pulse, 1);
            if (pulse) begin
                if (!prev_pulse) begin
                    chk("fair_owner", grant, exp_owner ? 4'b0010 : 4'b0001);
                    cur_g = grant;
                    width = 0;
                end else begin
                    chk("fair_grant_stable", grant, cur_g);
                end
                width++;
            end else if (prev_pulse) begin
                chk("fair_width", width, (cur_g == 4'b0001) ? 3 : 5);
                chk("fair_done", done, cur_g);
                pulses++;
                exp_owner = ~exp_owner;
            end
            prev_pulse = pulse;
            prev_done = done;
        end
        chk("fair_pulse_count", pulses, 20);
        req = 4'b0000;
        cycle();
        chk("fair_end_idle", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
